// File: rtl/acc_dp_pkg.sv
// Shared types and instruction-field helpers for the parameterised accumulator data path.
package acc_dp_pkg;

    localparam int unsigned OPC_W = 3;

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpAnd = 3'd1,
        OpSub = 3'd2,
        OpXor = 3'd3,
        OpLda = 3'd4,
        OpSta = 3'd5,
        OpSwp = 3'd6,
        OpIsz = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StRead   = 3'd2,
        StExec   = 3'd3,
        StWrite  = 3'd4
    } state_e;

    // Opcode occupies the top OPC_W bits of the instruction word.
    function automatic int unsigned opc_lsb(input int unsigned data_w);
        return data_w - OPC_W;
    endfunction

endpackage

// File: rtl/alu_p.sv
// Combinational ALU: ADD/AND/SUB/XOR and LDA pass-through; carry is only touched by ADD/SUB.
module alu_p
    import acc_dp_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] dr,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    always_comb begin
        sum       = {1'b0, ac} + {1'b0, dr};
        // Two's-complement subtract: carry-out is the no-borrow flag (ac >= dr).
        diff      = {1'b0, ac} + {1'b0, ~dr} + {{DATA_W{1'b0}}, 1'b1};
        result    = ac;
        carry_out = carry_in;
        unique case (opcode_e'(op))
            OpAdd: begin
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
            end
            OpAnd: result = ac & dr;
            OpSub: begin
                result    = diff[DATA_W-1:0];
                carry_out = diff[DATA_W];
            end
            OpXor: result = ac ^ dr;
            OpLda: result = dr;
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_datapath_p.sv
// Accumulator data path with its own fetch/decode/execute FSM and a req/ack memory port.
module acc_datapath_p
    import acc_dp_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              R,
    input  logic              en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ac_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              carry_flag,
    output logic              instr_done
);

    localparam int unsigned OpcLsb = opc_lsb(DATA_W);

    state_e            state_q;
    logic              run_q;
    logic [DATA_W-1:0] ac_q;
    logic [DATA_W-1:0] dr_q;
    logic [DATA_W-1:0] tr_q;
    logic [DATA_W-1:0] ir_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] ar_q;
    logic              carry_q;

    opcode_e           op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              exec_last;
    logic              unused_ir;

    assign op        = opcode_e'(ir_q[OpcLsb +: OPC_W]);
    assign unused_ir = ^ir_q;

    alu_p #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op        (ir_q[OpcLsb +: OPC_W]),
        .ac        (ac_q),
        .dr        (dr_q),
        .carry_in  (carry_q),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // run_q keeps the port quiet for the cycle after reset so the first
    // request appears only once R has been released.
    always_comb begin
        exec_last  = (state_q == StExec) && (op != OpSwp) && (op != OpIsz);
        mem_req    = run_q && ((state_q == StFetch) || (state_q == StRead) ||
                               (state_q == StWrite));
        mem_we     = run_q && (state_q == StWrite);
        mem_addr   = (state_q == StFetch) ? pc_q : ar_q;
        mem_wdata  = '0;
        if (state_q == StWrite) begin
            if (op == OpSwp) begin
                mem_wdata = tr_q;
            end else if (op == OpIsz) begin
                mem_wdata = dr_q;
            end else begin
                mem_wdata = ac_q;
            end
        end
        instr_done = en && run_q && (exec_last || ((state_q == StWrite) && mem_ack));
    end

    always_ff @(posedge clk) begin
        if (!R) begin
            state_q <= StFetch;
            run_q   <= 1'b0;
            ac_q    <= '0;
            dr_q    <= '0;
            tr_q    <= '0;
            ir_q    <= '0;
            pc_q    <= '0;
            ar_q    <= '0;
            carry_q <= 1'b0;
        end else if (en) begin
            run_q <= 1'b1;
            if (run_q) begin
                unique case (state_q)
                    StFetch: begin
                        if (mem_ack) begin
                            ir_q    <= mem_rdata;
                            pc_q    <= pc_q + ADDR_W'(1);
                            state_q <= StDecode;
                        end
                    end
                    StDecode: begin
                        ar_q    <= ir_q[ADDR_W-1:0];
                        state_q <= (op == OpSta) ? StWrite : StRead;
                    end
                    StRead: begin
                        if (mem_ack) begin
                            dr_q    <= mem_rdata;
                            state_q <= StExec;
                        end
                    end
                    StExec: begin
                        case (op)
                            OpSwp: begin
                                tr_q    <= ac_q;
                                ac_q    <= dr_q;
                                state_q <= StWrite;
                            end
                            OpIsz: begin
                                dr_q    <= dr_q + DATA_W'(1);
                                state_q <= StWrite;
                            end
                            default: begin
                                ac_q    <= alu_result;
                                carry_q <= alu_carry;
                                state_q <= StFetch;
                            end
                        endcase
                    end
                    StWrite: begin
                        if (mem_ack) begin
                            // dr_q already holds the incremented ISZ value here.
                            if ((op == OpIsz) && (dr_q == '0)) begin
                                pc_q <= pc_q + ADDR_W'(1);
                            end
                            state_q <= StFetch;
                        end
                    end
                    default: state_q <= StFetch;
                endcase
            end
        end
    end

    assign ac_out     = ac_q;
    assign pc_out     = pc_q;
    assign carry_flag = carry_q;

endmodule

// File: doc/acc_datapath_p.md
# acc_datapath_p

Parameterised successor to the fixed 8-bit accumulator data path. It runs its own fetch/decode/execute state machine instead of relying on an external T-state decoder, and widths are set by parameters. Memory is reached through a single req/ack handshake port, so wait-state memory is supported. The block sits between the control/top level and unified instruction/data memory, and exposes AC, PC and a carry flag.

## Interface
- `DATA_W`, 8, width of AC, DR, TR, IR and memory words; must be ≥ `ADDR_W`+3
- `ADDR_W`, 5, width of PC, AR and memory address
- `clk`  in  1  single clock; all state changes on rising edge
- `R`  in  1  reset; synchronous, active-low
- `en`  in  1  sequencing enable; low freezes the FSM and all registers (an outstanding `mem_req` stays asserted)
- `mem_req`  out  1  memory request; held until accepted
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`
- `mem_addr`  out  ADDR_W  request address
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  read data; sampled on the accept edge
- `mem_ack`  in  1  a transfer completes on a rising edge where `mem_req`&`mem_ack`&`en`; may be high in the same cycle as `mem_req`
- `ac_out`  out  DATA_W  accumulator
- `pc_out`  out  ADDR_W  program counter
- `carry_flag`  out  1  carry/no-borrow flag
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction

## Operation
- Instruction word: opcode = IR[DATA_W-1:DATA_W-3]; operand address = IR[ADDR_W-1:0]; bits in between are ignored.
- Opcodes:
  - 0 ADD: AC←AC+M; carry = carry-out
  - 1 AND: AC←AC&M
  - 2 SUB: AC←AC−M; carry = 1 iff AC ≥ M (unsigned)
  - 3 XOR: AC←AC^M
  - 4 LDA: AC←M
  - 5 STA: M←AC
  - 6 SWP: AC←M, M←old AC (old AC held in TR)
  - 7 ISZ: M←M+1 mod 2^DATA_W; if the result is 0, PC←PC+1
- Carry is written only by ADD and SUB; every other opcode leaves it unchanged.
- FSM states:
  - FETCH: read at PC. On accept: IR←rdata, PC←PC+1.
  - DECODE: AR←IR address field. Next state is WRITE for STA, READ otherwise.
  - READ: read at AR. On accept: DR←rdata.
  - EXEC: ALU ops and LDA update AC/carry, then go to FETCH (`instr_done`). SWP: TR←AC, AC←DR, go to WRITE. ISZ: DR←DR+1, go to WRITE.
  - WRITE: write at AR; wdata = AC for STA, TR for SWP, DR for ISZ. On accept: `instr_done`, and for ISZ with DR==0, PC←PC+1. Go to FETCH.
- Wrap: PC and the skip increment wrap from 2^ADDR_W−1 to 0. ISZ on 2^DATA_W−1 writes 0 and skips.
- Reset (R low at an edge): AC, DR, TR, IR, PC, AR and carry all ←0; state←FETCH; `mem_req`, `mem_we`, `instr_done` = 0 in the next cycle. A transfer pending at reset is abandoned, and any `mem_ack` in that cycle is ignored.
- Reset has priority over `en`.

## Timing
- `mem_req` is combinational from state: high in FETCH, READ and WRITE.
- `mem_addr`, `mem_we` and `mem_wdata` are stable for the whole request.
- Each memory state adds one cycle per wait cycle of `mem_ack` low.
- Cycle counts with `mem_ack` tied high:
  - ADD/AND/SUB/XOR/LDA: 4
  - STA: 3
  - SWP: 5
  - ISZ: 5
- The first `mem_req` (FETCH at address 0) appears in the cycle after R is released.
- `instr_done` is asserted in the cycle whose rising edge completes the instruction.

## Structure
- Package `acc_dp_pkg`: opcode enum (ADD…ISZ), FSM state enum, field-position localparams derived from `DATA_W`/`ADDR_W`.
- Sub-module `alu_p` (parameter `DATA_W`): combinational; inputs op, AC, DR, carry_in; outputs result, carry_out.
- Registers and FSM live in `acc_datapath_p`.

## Test plan
- Reset then ack tied high, mem[0]=0x83 (LDA 3), mem[3]=0x2A → `ac_out`=0x2A after 4 cycles, `pc_out`=1, one `instr_done`.
- AC=0xF0, ADD of M=0x20 → AC=0x10, carry=1. Then SUB of M=0x20 → AC=0xF0, carry=0.
- ISZ on M=0xFF at PC=4 → mem written 0x00, `pc_out`=6. ISZ on M=0x05 → mem written 0x06, no skip.
- SWP with AC=0x11, M=0x77 → AC=0x77, write of 0x11 to the operand address, 5 cycles.
- `mem_ack` delayed 3 cycles on each request, `en` toggled mid-READ → same architectural results; address/data stable while `mem_req` is high; cycle count grows exactly by the waits plus the disabled cycles.
- R low during WRITE of STA with ack low → no write is accepted; next cycle `mem_req`=0 and all outputs are 0; after release, FETCH from address 0.
